output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5: number of input routers contending for one output port (index 0=Local, 1=N, 2=S, 3=E, 4=W).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: stall limit in cycles, used only under ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  input  NUM_REQ  per-requester request; bit i is that input router's router_port_o bit for this output.
REQ-006 SHALL have port tail_i  input  NUM_REQ  per-requester flag; the flit presented by requester i is the last flit of its packet (tail, or head+tail).
REQ-007 SHALL have port ready_i  input  1  downstream can accept a flit this cycle.
REQ-008 SHALL have port grant_o  output  NUM_REQ  registered one-hot grant, or all-zero.
REQ-009 SHALL have port valid_o  output  1  flit from the granted requester is valid on the output this cycle.
REQ-010 SHALL have port lock_o  output  1  arbiter is in LOCKED state.
REQ-011 SHALL have port timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-013 In IDLE with req_i nonzero, SHALL select the first set bit at or after rr_ptr, searching cyclically (ptr, ptr+1, ... NUM_REQ-1, 0, ...).
REQ-014 SHALL register that selection into grant_o and enter LOCKED at the next edge; latency from request to grant is 1 cycle.
REQ-015 In IDLE with req_i zero, SHALL hold grant_o=0 and stay in IDLE.
REQ-016 valid_o SHALL be combinational: OR of (grant_o & req_i).
REQ-017 A transfer SHALL occur in any cycle with valid_o=1 and ready_i=1.
REQ-018 A transfer with tail_i of the owner set SHALL release the lock at that edge, giving state IDLE, grant_o=0, and rr_ptr=(owner+1) mod NUM_REQ (4 wraps to 0).
REQ-019 After a release, SHALL insert exactly one IDLE cycle before the next grant; there is no same-cycle regrant.
REQ-020 In LOCKED, SHALL keep the grant even if the owner drops req_i (wormhole hold); other requests SHALL be ignored.
REQ-021 rr_ptr SHALL change only on release.
REQ-022 grant_o SHALL never have more than one bit set.
REQ-023 lock_o SHALL be 1 exactly when state is LOCKED.

Reset
REQ-024 arst=1 at an edge SHALL force state=IDLE, grant_o=0, rr_ptr=0, stall counter=0 and timeout_o=0, including mid-packet.
REQ-025 valid_o SHALL be 0 in the first cycle after reset.
REQ-026 arst SHALL take priority over every other event at the same edge.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined:
- SHALL keep a stall counter of width clog2(TIMEOUT_CYCLES+1).
- The counter SHALL increment in each LOCKED cycle without a transfer, and clear on any transfer and on entering IDLE.
- When the counter reaches TIMEOUT_CYCLES, SHALL force a release exactly as in REQ-018 and pulse timeout_o for one cycle.
REQ-028 Without ARB_TIMEOUT_EN, SHALL have no counter logic, tie timeout_o to 0, and release the lock only on a tail transfer or reset.

Verification
REQ-029 Reset, then req_i=5'b00110 held -> grant_o=5'b00010 one cycle later; after its tail transfer with ready_i=1, one cycle with grant_o=0, then grant_o=5'b00100.
REQ-030 req_i=5'b11111 held, ready_i=1, every flit a tail -> grant order 0,1,2,3,4,0 with one idle cycle between grants.
REQ-031 Owner 3 locked on a 4-flit packet, ready_i low for 3 cycles mid-packet, req_i[1]=1 throughout -> grant_o stays 5'b01000 until the tail transfers; lock_o=1 throughout.
REQ-032 arst=1 during the second flit of a locked packet -> next cycle grant_o=0, lock_o=0, valid_o=0, and the next grant searches from index 0.
REQ-033 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner 2 locked, ready_i=0 for 16 cycles -> timeout_o pulses once, grant_o=0, next search starts at index 3. Without the macro -> still locked, timeout_o=0.
REQ-034 Owner 4 releases while req_i[0]=1 and req_i[4]=1 -> rr_ptr wraps to 0, and the next grant is 5'b00001.

Source files
------------

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the contending input routers and one output-port arbiter.
// The arbiter takes the slave view; the routers (or a bench) take the master view.
interface output_arbiter_if #(
  parameter int NUM_REQ = 5
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] tail_i;
  logic               ready_i;
  logic [NUM_REQ-1:0] grant_o;
  logic               valid_o;
  logic               lock_o;
  logic               timeout_o;

  modport master (
    output req_i, tail_i, ready_i,
    input  grant_o, valid_o, lock_o, timeout_o
  );

  modport slave (
    input  req_i, tail_i, ready_i,
    output grant_o, valid_o, lock_o, timeout_o
  );
endinterface

// File: rtl/output_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks onto a packet until its tail transfers.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module output_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            arst,
  output_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               timeout_q, timeout_d;

  logic               sel_found_s;
  logic [PTR_W-1:0]   sel_idx_s;
  logic [PTR_W-1:0]   cand_idx_s;
  int                 cand_sum_s;
  logic               valid_s;
  logic               xfer_s;
  logic               release_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_q, stall_d;
`endif

  assign valid_s = |(grant_q & bus.req_i);
  assign xfer_s  = valid_s & bus.ready_i;

  // Cyclic first-set search starting at the round-robin pointer.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_sum_s  = 0;
    cand_idx_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s = int'(rr_ptr_q) + k;
      cand_idx_s = (cand_sum_s >= NUM_REQ) ? PTR_W'(cand_sum_s - NUM_REQ) : PTR_W'(cand_sum_s);
      if (!sel_found_s && bus.req_i[cand_idx_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state logic: grant on request in IDLE, hold the lock until tail transfer or watchdog.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timeout_d = 1'b0;
    release_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d = LOCKED;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
          owner_d = sel_idx_s;
        end else begin
          grant_d = '0;
        end
      end
      LOCKED: begin
        if (xfer_s && bus.tail_i[owner_q]) begin
          release_s = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (!xfer_s) begin
          // The edge on which the counter would reach the limit is the forced release.
          if (stall_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            release_s = 1'b1;
            timeout_d = 1'b1;
          end else begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`endif
        end else begin
          release_s = 1'b0;
        end
        if (release_s) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      stall_q   <= stall_d;
`endif
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.valid_o   = valid_s;
  assign bus.lock_o    = (state_q == LOCKED);
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: a per-cycle packet-level model plus hand-computed checkpoints.
module tb_output_arbiter;
  localparam int N  = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic arst;
  int   checks   = 0;
  int   failures = 0;

  output_arbiter_if #(.NUM_REQ(N)) bus ();

  output_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: who owns the port, where the next search starts, how long it has stalled.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_to    = 1'b0;
  bit m_ok    = 1'b0;

  always @(posedge clk) begin
    m_ok = 1'b1;
    if (arst) begin
      m_owner = -1; m_ptr = 0; m_stall = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && bus.req_i[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
      end else if (bus.req_i[m_owner] && bus.ready_i) begin
        m_stall = 0;
        if (bus.tail_i[m_owner]) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
      end else begin
        m_stall++;
`ifdef ARB_TIMEOUT_EN
        if (m_stall == TO) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_stall = 0; m_to = 1'b1;
        end
`endif
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_grant", bus.grant_o, (m_owner < 0) ? 0 : (1 << m_owner));
      chk("model_lock", bus.lock_o, (m_owner >= 0));
      chk("model_valid", bus.valid_o, (m_owner >= 0) ? bus.req_i[m_owner] : 1'b0);
      chk("model_timeout", bus.timeout_o, m_to);
    end
  end

  task automatic tick(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic rd);
    @(posedge clk);
    #1;
    arst = r; bus.req_i = rq; bus.tail_i = tl; bus.ready_i = rd;
    @(negedge clk);
  endtask

  logic [4:0] rr_seq [11] = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000,
                              5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001};

  initial begin
    arst = 1'b1; bus.req_i = 5'b0; bus.tail_i = 5'b0; bus.ready_i = 1'b0;
    tick(1'b1, 5'b00000, 5'b00000, 1'b0);
    tick(1'b0, 5'b00000, 5'b00000, 1'b0);
    chk("reset_grant", bus.grant_o, 5'b00000);
    chk("reset_lock", bus.lock_o, 1'b0);
    chk("reset_valid", bus.valid_o, 1'b0);

    // Two requesters, search from 0: 1 wins, then one idle cycle, then 2.
    tick(1'b0, 5'b00110, 5'b00000, 1'b0);
    chk("first_req_latency", bus.grant_o, 5'b00000);
    tick(1'b0, 5'b00110, 5'b00010, 1'b1);
    chk("grant_owner1", bus.grant_o, 5'b00010);
    chk("valid_owner1", bus.valid_o, 1'b1);
    tick(1'b0, 5'b00110, 5'b00000, 1'b1);
    chk("idle_gap", bus.grant_o, 5'b00000);
    tick(1'b0, 5'b00110, 5'b00100, 1'b1);
    chk("grant_owner2", bus.grant_o, 5'b00100);
    tick(1'b0, 5'b00000, 5'b00000, 1'b0);

    // All request, single-flit packets: full rotation including wrap from 4 to 0.
    tick(1'b1, 5'b00000, 5'b00000, 1'b0);
    tick(1'b0, 5'b11111, 5'b11111, 1'b1);
    chk("rr_start_idle", bus.grant_o, 5'b00000);
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, 5'b11111, 5'b11111, 1'b1);
      chk("rr_order", bus.grant_o, rr_seq[i]);
    end

    // Owner 1 single flit moves the pointer to 2; then owner 3 holds through stalls.
    tick(1'b0, 5'b00010, 5'b00010, 1'b1);
    tick(1'b0, 5'b00010, 5'b00010, 1'b1);
    chk("grant_owner1_again", bus.grant_o, 5'b00010);
    tick(1'b0, 5'b01010, 5'b00000, 1'b0);
    tick(1'b0, 5'b01010, 5'b00000, 1'b1);
    chk("grant_owner3", bus.grant_o, 5'b01000);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 5'b01010, 5'b00000, 1'b0);
      chk("stall_hold_grant", bus.grant_o, 5'b01000);
      chk("stall_hold_lock", bus.lock_o, 1'b1);
    end
    tick(1'b0, 5'b01010, 5'b00000, 1'b1);
    tick(1'b0, 5'b01010, 5'b00000, 1'b1);
    tick(1'b0, 5'b01010, 5'b01000, 1'b1);
    chk("tail_still_owner3", bus.grant_o, 5'b01000);
    tick(1'b0, 5'b00010, 5'b00000, 1'b0);
    chk("after_owner3_idle", bus.grant_o, 5'b00000);

    // Reset mid-packet: next search restarts at 0 even though the pointer was 4.
    tick(1'b0, 5'b00010, 5'b00000, 1'b1);
    chk("grant_owner1_pre_reset", bus.grant_o, 5'b00010);
    tick(1'b1, 5'b00010, 5'b00000, 1'b1);
    tick(1'b0, 5'b00011, 5'b00000, 1'b0);
    chk("midpkt_reset_grant", bus.grant_o, 5'b00000);
    chk("midpkt_reset_lock", bus.lock_o, 1'b0);
    chk("midpkt_reset_valid", bus.valid_o, 1'b0);
    tick(1'b0, 5'b00011, 5'b00001, 1'b1);
    chk("post_reset_from0", bus.grant_o, 5'b00001);

    // Owner 2 stalled for the full limit.
    tick(1'b0, 5'b00100, 5'b00000, 1'b0);
    for (int i = 0; i < TO; i++) begin
      tick(1'b0, 5'b00100, 5'b00000, 1'b0);
      chk("stall_owner2", bus.grant_o, 5'b00100);
      chk("stall_no_timeout", bus.timeout_o, 1'b0);
    end
    tick(1'b0, 5'b00101, 5'b00000, 1'b0);
`ifdef ARB_TIMEOUT_EN
    chk("timeout_release", bus.grant_o, 5'b00000);
    chk("timeout_pulse", bus.timeout_o, 1'b1);
    tick(1'b0, 5'b00101, 5'b00001, 1'b1);
    chk("timeout_ptr3", bus.grant_o, 5'b00001);
    chk("timeout_single", bus.timeout_o, 1'b0);
`else
    chk("no_timeout_locked", bus.grant_o, 5'b00100);
    chk("no_timeout_pulse", bus.timeout_o, 1'b0);
    tick(1'b0, 5'b00101, 5'b00100, 1'b1);
    chk("no_timeout_tail", bus.grant_o, 5'b00100);
`endif
    tick(1'b0, 5'b00000, 5'b00000, 1'b0);
    tick(1'b0, 5'b00000, 5'b00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
